// File: rtl/barrett_arbiter_pkg.sv
// Shared definitions for the Barrett reduction arbiter: operand width,
// FSM state encoding and the requester-ID width helper.
package barrett_arbiter_pkg;

    localparam int DATA_LENGTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } barrett_arb_state_e;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/barrett_arbiter_tag_fifo.sv
// Small synchronous FIFO holding the requester IDs of in-flight reductions.
// The head entry is visible combinationally so a result can be routed in the cycle it arrives.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_en) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/barrett_arbiter.sv
// Round-robin arbiter sharing one pipelined Barrett reduction unit between NUM_REQ requesters.
// Define BARRETT_ARB_STATS_EN to add the stat_issued_o / stat_drain_o counters.
module barrett_arbiter
    import barrett_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_bl_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_mu_i,
    output logic                           unit_start_o,
    output logic [DATA_LENGTH-1:0]         unit_x_o,
    output logic [DATA_LENGTH-1:0]         unit_m_o,
    output logic [DATA_LENGTH-1:0]         unit_m_bl_o,
    output logic [DATA_LENGTH-1:0]         unit_mu_o,
    input  logic [DATA_LENGTH-1:0]         unit_result_i,
    input  logic                           unit_valid_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic [DATA_LENGTH-1:0]         resp_data_o,
    output logic                           err_o
`ifdef BARRETT_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_issued_o,
    output logic [31:0]                    stat_drain_o
`endif
);
    localparam int ID_W       = id_width(NUM_REQ);
    localparam int FIFO_DEPTH = PIPE_LAT + 1;

    logic [DATA_LENGTH-1:0] x_arr  [NUM_REQ];
    logic [DATA_LENGTH-1:0] m_arr  [NUM_REQ];
    logic [DATA_LENGTH-1:0] bl_arr [NUM_REQ];
    logic [DATA_LENGTH-1:0] mu_arr [NUM_REQ];

    barrett_arb_state_e state_reg;
    barrett_arb_state_e state_next;

    logic [ID_W-1:0]        rr_ptr_reg;
    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        winner_inc;
    logic [ID_W-1:0]        tag_head;
    logic                   found;
    logic                   match;
    logic                   grant;
    logic                   mismatch_stall;
    logic                   fifo_full;
    logic                   fifo_empty;
    int                     idx;

    logic                   start_reg;
    logic [DATA_LENGTH-1:0] x_reg;
    logic [DATA_LENGTH-1:0] m_reg;
    logic [DATA_LENGTH-1:0] bl_reg;
    logic [DATA_LENGTH-1:0] mu_reg;
    logic [NUM_REQ-1:0]     resp_valid_reg;
    logic [DATA_LENGTH-1:0] resp_data_reg;
    logic                   err_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign x_arr[gi]       = req_x_i[gi*DATA_LENGTH +: DATA_LENGTH];
        assign m_arr[gi]       = req_m_i[gi*DATA_LENGTH +: DATA_LENGTH];
        assign bl_arr[gi]      = req_m_bl_i[gi*DATA_LENGTH +: DATA_LENGTH];
        assign mu_arr[gi]      = req_mu_i[gi*DATA_LENGTH +: DATA_LENGTH];
        assign req_ready_o[gi] = grant && (winner == ID_W'(gi));
    end

    // First valid requester at or after rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_REQ;
            if (!found && req_valid_i[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign winner_inc = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // The unit reads m/m_bl/mu live, so a new modulus may only go out with nothing in flight.
    assign match = (m_arr[winner] == m_reg) && (bl_arr[winner] == bl_reg)
                   && (mu_arr[winner] == mu_reg);
    assign grant          = !rst_i && found && !fifo_full && (fifo_empty || match);
    assign mismatch_stall = found && !fifo_empty && !match;

    always_comb begin
        state_next = state_reg;
        if (grant) begin
            state_next = ISSUE;
        end else if (mismatch_stall) begin
            state_next = DRAIN;
        end else if (fifo_empty) begin
            state_next = IDLE;
        end
    end

    tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (grant),
        .push_data (winner),
        .pop       (unit_valid_i),
        .pop_data  (tag_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            start_reg      <= 1'b0;
            x_reg          <= '0;
            m_reg          <= '0;
            bl_reg         <= '0;
            mu_reg         <= '0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= grant;
            if (grant) begin
                rr_ptr_reg <= winner_inc;
                x_reg      <= x_arr[winner];
                if (fifo_empty) begin
                    m_reg  <= m_arr[winner];
                    bl_reg <= bl_arr[winner];
                    mu_reg <= mu_arr[winner];
                end
            end
            resp_valid_reg <= '0;
            if (unit_valid_i) begin
                if (fifo_empty) begin
                    err_reg <= 1'b1;
                end else begin
                    resp_valid_reg[tag_head] <= 1'b1;
                    resp_data_reg            <= unit_result_i;
                end
            end
        end
    end

    assign unit_start_o = start_reg;
    assign unit_x_o     = x_reg;
    assign unit_m_o     = m_reg;
    assign unit_m_bl_o  = bl_reg;
    assign unit_mu_o    = mu_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_data_o  = resp_data_reg;
    assign err_o        = err_reg;

`ifdef BARRETT_ARB_STATS_EN
    logic [31:0] stat_issued_reg;
    logic [31:0] stat_drain_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_issued_reg <= '0;
            stat_drain_reg  <= '0;
        end else begin
            if (grant && (stat_issued_reg != '1)) begin
                stat_issued_reg <= stat_issued_reg + 32'd1;
            end
            if ((state_reg == DRAIN) && (stat_drain_reg != '1)) begin
                stat_drain_reg <= stat_drain_reg + 32'd1;
            end
        end
    end

    assign stat_issued_o = stat_issued_reg;
    assign stat_drain_o  = stat_drain_reg;
`endif

endmodule
